// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared types and constants for the branch predictor
package branch_predict_unit_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam int   PC_INC    = 4;

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - IF/ID-facing signal bundle of the branch predictor
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] pred_pc;
  logic              pred_taken;
  logic              res_valid;
  logic [ADDR_W-1:0] res_pc;
  logic              res_taken;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_target;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  mispredict_count;

  modport master (
    output pred_pc, res_valid, res_pc, res_taken, res_pred_taken, res_target,
    input  pred_taken, flush, redirect_pc, branch_count, mispredict_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, res_taken, res_pred_taken, res_target,
    output pred_taken, flush, redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// rtl/branch_predict_unit_sat_counter2.sv - 2-bit saturating up/down next-state logic
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  ctr_t i_cur,
  input  logic i_taken,
  output ctr_t o_next
);

  always_comb begin
    o_next = i_cur;
    case (i_cur)
      CTR_SNT: o_next = i_taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: o_next = i_taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  o_next = i_taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  o_next = i_taken ? CTR_ST  : CTR_WT;
      default: o_next = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit counter direction predictor with registered
// mispredict flush/redirect and saturating statistics
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);

  localparam int TABLE_N = 1 << IDX_BITS;

  ctr_t              r_table [TABLE_N];
  logic              r_flush;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic [CNT_W-1:0]  r_branch_count;
  logic [CNT_W-1:0]  r_mispredict_count;

  logic [IDX_BITS-1:0] w_pred_idx;
  logic [IDX_BITS-1:0] w_res_idx;
  ctr_t                w_pred_ctr;
  ctr_t                w_res_ctr;
  ctr_t                w_res_next;
  logic                w_accept;
  logic                w_mispredict;

  assign w_pred_idx = bus.pred_pc[IDX_BITS+1:2];
  assign w_res_idx  = bus.res_pc[IDX_BITS+1:2];
  assign w_pred_ctr = r_table[w_pred_idx];
  assign w_res_ctr  = r_table[w_res_idx];

  // A resolution arriving while flush is high is on the wrong path.
  assign w_accept     = bus.res_valid & ~r_flush;
  assign w_mispredict = w_accept & (bus.res_taken ^ bus.res_pred_taken);

  sat_counter2 u_sat_counter2 (
    .i_cur   (w_res_ctr),
    .i_taken (bus.res_taken),
    .o_next  (w_res_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_N; i++) r_table[i] <= CTR_RESET;
    end else if (w_accept) begin
      r_table[w_res_idx] <= w_res_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict)
        r_redirect_pc <= bus.res_taken ? bus.res_target : bus.res_pc + ADDR_W'(PC_INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_accept && r_branch_count != '1)
        r_branch_count <= r_branch_count + 1'b1;
      if (w_mispredict && r_mispredict_count != '1)
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign bus.pred_taken       = w_pred_ctr[1];
  assign bus.flush            = r_flush;
  assign bus.redirect_pc      = r_redirect_pc;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed and random checks of branch_predict_unit
`timescale 1ns/1ps
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.ADDR_W(32), .CNT_W(32)) b0 ();
  branch_predict_unit_if #(.ADDR_W(32), .CNT_W(4))  b1 ();

  branch_predict_unit #(.IDX_BITS(6), .ADDR_W(32), .CNT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  branch_predict_unit #(.IDX_BITS(6), .ADDR_W(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  int n_checks = 0;
  int n_errors = 0;

  int          m_tbl [64];
  logic        m_flush;
  logic [31:0] m_redir;
  longint      m_br;
  longint      m_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    m_flush = 1'b0;
    m_redir = 32'h0;
    m_br    = 0;
    m_mis   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".flush"},     {63'h0, b0.flush},  {63'h0, m_flush});
    check({tag, ".redirect"},  {32'h0, b0.redirect_pc}, {32'h0, m_redir});
    check({tag, ".br32"},      {32'h0, b0.branch_count}, m_br);
    check({tag, ".mis32"},     {32'h0, b0.mispredict_count}, m_mis);
    check({tag, ".br4"},       {60'h0, b1.branch_count}, sat15(m_br));
    check({tag, ".mis4"},      {60'h0, b1.mispredict_count}, sat15(m_mis));
    check({tag, ".flush4"},    {63'h0, b1.flush}, {63'h0, m_flush});
  endtask

  // One pipeline cycle: drive, check the lookup before the edge, then check registered results.
  task automatic step(input string tag, input logic v, input logic [31:0] pc, input logic t,
                      input logic pt, input logic [31:0] tgt, input logic [31:0] ppc);
    logic accept, mis;
    int   idx;
    b0.pred_pc = ppc; b0.res_valid = v; b0.res_pc = pc; b0.res_taken = t;
    b0.res_pred_taken = pt; b0.res_target = tgt;
    b1.pred_pc = ppc; b1.res_valid = v; b1.res_pc = pc; b1.res_taken = t;
    b1.res_pred_taken = pt; b1.res_target = tgt;
    @(negedge clk);
    check({tag, ".pred"}, {63'h0, b0.pred_taken}, {63'h0, (m_tbl[(ppc >> 2) % 64] >= 2)});
    check({tag, ".pred4"}, {63'h0, b1.pred_taken}, {63'h0, (m_tbl[(ppc >> 2) % 64] >= 2)});
    accept = v && !m_flush;
    mis    = accept && (t != pt);
    @(posedge clk);
    #1;
    if (accept) begin
      idx = (pc >> 2) % 64;
      m_tbl[idx] = t ? ((m_tbl[idx] == 3) ? 3 : m_tbl[idx] + 1)
                     : ((m_tbl[idx] == 0) ? 0 : m_tbl[idx] - 1);
      m_br++;
    end
    if (mis) begin
      m_mis++;
      m_redir = t ? tgt : pc + 32'd4;
    end
    m_flush = mis;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic [31:0] ppc);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, ppc);
  endtask

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0110;
  localparam logic [31:0] TGT  = 32'h0040_0100;

  initial begin
    logic [31:0] rpc, ppc;
    model_reset();
    b0.pred_pc = PC_A; b0.res_valid = 0; b0.res_pc = 0; b0.res_taken = 0;
    b0.res_pred_taken = 0; b0.res_target = 0;
    b1.pred_pc = PC_A; b1.res_valid = 0; b1.res_pc = 0; b1.res_taken = 0;
    b1.res_pred_taken = 0; b1.res_target = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs("reset");
    check("reset.pred", {63'h0, b0.pred_taken}, 64'h0);

    idle("idle0", PC_A);
    step("mp_taken", 1'b1, PC_A, 1'b1, 1'b0, TGT, PC_A);
    idle("gap0", PC_A);
    step("ok_taken", 1'b1, PC_A, 1'b1, 1'b1, TGT, PC_A);
    idle("st_pred", PC_A);
    check("entry_st", {63'h0, b0.pred_taken}, 64'h1);

    step("mp_nt", 1'b1, PC_A, 1'b0, 1'b1, TGT, PC_A);
    idle("after_nt", PC_A);

    // Second mispredict pattern directly behind a flush must be dropped.
    step("mask_a", 1'b1, PC_A, 1'b0, 1'b1, TGT, PC_A);
    step("mask_b", 1'b1, PC_B, 1'b1, 1'b0, 32'h1234_5678, PC_A);
    idle("mask_c", PC_A);

    // Aliased PCs; same-cycle lookup must still return the pre-update entry.
    step("alias_upd", 1'b1, PC_A, 1'b1, 1'b1, TGT, PC_B);
    idle("alias_look", PC_B);
    step("alias_same", 1'b1, PC_B, 1'b0, 1'b0, TGT, PC_A);
    step("alias_same2", 1'b1, PC_B, 1'b0, 1'b0, TGT, PC_A);
    idle("alias_after", PC_A);

    step("wrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, TGT, 32'hFFFF_FFFC);
    idle("wrap_after", 32'hFFFF_FFFC);

    for (int i = 0; i < 300; i++) begin
      rpc = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      ppc = 32'h0040_0000 | (32'($urandom_range(0, 9)) << 2);
      step("rand", 1'($urandom_range(0, 3) != 0), rpc, 1'($urandom), 1'($urandom),
           $urandom, ppc);
    end

    // Asynchronous reset with a flush pending, checked between clock edges.
    step("pre_rst", 1'b1, PC_A, 1'b1, 1'b0, TGT, PC_A);
    if (!m_flush) step("pre_rst2", 1'b1, PC_A, 1'b0, 1'b1, TGT, PC_A);
    rst_n = 1'b0;
    #0.5;
    model_reset();
    check("arst.flush", {63'h0, b0.flush}, 64'h0);
    check("arst.redirect", {32'h0, b0.redirect_pc}, 64'h0);
    check("arst.br", {32'h0, b0.branch_count}, 64'h0);
    check("arst.mis", {32'h0, b0.mispredict_count}, 64'h0);
    check("arst.pred", {63'h0, b0.pred_taken}, 64'h0);
    #0.5;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      step("sat", 1'b1, PC_A, 1'b1, (i >= 1), TGT, PC_A);
    check("sat.br4_final", {60'h0, b1.branch_count}, 64'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Sits at the consuming end of the ID-stage branch comparator (beq/bne resolution). It predicts branch direction for the IF stage from a table of 2-bit saturating counters.
- It accepts the resolved outcome from the comparator and trains the table.
- On a misprediction it issues a registered flush and redirect PC to the fetch unit.
- It keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- IDX_BITS, 6, log2 of table entries (64 entries); index = PC[IDX_BITS+1:2]
- ADDR_W, 32, PC width
- CNT_W, 32, width of statistics counters

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pred_pc  input  ADDR_W  PC of instruction in IF
- pred_taken  output  1  combinational prediction for pred_pc (counter MSB)
- res_valid  input  1  ID holds a conditional branch whose outcome is resolved this cycle
- res_pc  input  ADDR_W  PC of the resolving branch
- res_taken  input  1  actual outcome from the comparator (1 = taken)
- res_pred_taken  input  1  prediction carried down the pipe with that branch
- res_target  input  ADDR_W  branch target address
- flush  output  1  registered; kill the IF instruction and redirect
- redirect_pc  output  ADDR_W  registered; valid when flush = 1
- branch_count  output  CNT_W  accepted resolutions, saturating
- mispredict_count  output  CNT_W  accepted mispredictions, saturating

Behaviour:
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction is taken iff MSB = 1.
- Reset (async, rst_n low):
  - all table entries = 01 (WNT)
  - flush = 0, redirect_pc = 0
  - both counters = 0
  - takes effect immediately, including mid-operation. Any pending flush is dropped.
- Lookup: pred_taken is combinational from the current table contents. There is no write-to-read bypass: a same-cycle update to the same index is visible on the next cycle only.
- Accept condition: accept = res_valid & ~flush.
  - res_valid while flush = 1 belongs to a wrong-path instruction. It is ignored: no table update, no counter change, no new flush.
- Table update, on the clock edge after an accepted resolution:
  - res_taken = 1: entry increments, saturating at 11.
  - res_taken = 0: entry decrements, saturating at 00.
  - Only index res_pc[IDX_BITS+1:2] changes. Aliasing between PCs is permitted.
- Mispredict = accept & (res_taken != res_pred_taken).
  - Next edge: flush = 1 for exactly one cycle.
  - redirect_pc = res_target if res_taken, else res_pc + 4 (mod 2^ADDR_W; wrap at 0xFFFFFFFC gives 0).
  - Otherwise flush = 0 next edge. redirect_pc holds its last value.
- Back-to-back: mispredicts in consecutive accepted cycles are impossible, because the second is masked by flush. Consecutive correctly predicted branches are accepted every cycle.
- Statistics counters:
  - branch_count increments on each accepted resolution.
  - mispredict_count increments on each mispredict.
  - Both saturate at all-ones and never wrap.
- Latency:
  - prediction: 0 cycles
  - flush/redirect: 1 cycle after resolution
  - training visible: 1 cycle after resolution
- No stall input. The pipeline must hold res_valid low while ID is stalled so an outcome is accepted once.

Decomposition:
- Shared package:
  - 2-bit counter state constants (SNT/WNT/WT/ST)
  - reset state WNT
  - PC increment constant 4
- Sub-module: sat_counter2, the 2-bit saturating up/down next-state logic instantiated once on the update path.
- Table storage, index extraction, flush register and statistics stay in the top module.

Test Plan:
- Reset, then pred_pc = 0x00400010 → pred_taken = 0. Assert rst_n = 0 for 1 ns mid-run → flush = 0 and counters = 0 immediately.
- Two accepted resolutions, res_pc = 0x00400010, res_taken = 1, res_pred_taken = 0 then 1:
  - first → flush = 1 next cycle, redirect_pc = res_target = 0x00400100
  - second → flush = 0
  - entry goes 01→10→11; pred_taken = 1
  - branch_count = 2, mispredict_count = 1
- Entry at ST, res_taken = 0, res_pred_taken = 1, res_pc = 0x00400010:
  - redirect_pc = 0x00400014, flush pulse of 1 cycle
  - entry 11→10; prediction still taken
- Mispredict at cycle t, then res_valid = 1 with a mispredict pattern at t+1 → ignored: no second flush, counters unchanged, table unchanged.
- Aliasing: resolve taken at 0x00400010, then look up 0x00400110 (same index, IDX_BITS = 6) → sees the updated entry. A same-cycle update/lookup on the same index returns the old value.
- Saturation:
  - preload statistics near max via a CNT_W = 4 build; 16 accepted resolutions → branch_count stays at 0xF
  - res_pc = 0xFFFFFFFC not-taken mispredict → redirect_pc = 0x00000000
